// File: rtl/servo_pkg.sv
// Shared constants and helpers for the turret servo PWM bank.
// Pure declarations: no logic, no latency, no flow control.
package servo_pkg;

    localparam int SERVO_N_CH   = 3;
    localparam int SERVO_CNT_W  = 20;
    localparam int SERVO_PERIOD = 500000;
    localparam int SERVO_MIN_PW = 25000;
    localparam int SERVO_MAX_PW = 50000;

    localparam int CH_PAN  = 0;
    localparam int CH_TILT = 1;
    localparam int CH_FIRE = 2;

    // Unsigned saturate of a requested width into [lo, hi].
    function automatic logic [31:0] clamp_pw(
        input logic [31:0] pw,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        logic [31:0] r;
        r = pw;
        if (pw < lo) begin
            r = lo;
        end else if (pw > hi) begin
            r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/servo_pwm_channel.sv
// One servo channel: shadow/active width, latched enable, registered compare output.
// Latency: counter value c is reflected on pwm one clock later; writes land at the next frame load.
// Backpressure: none, every write strobe is accepted and the last write in a frame wins.
module servo_pwm_channel #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt,
    input  logic             frame_load,
    input  logic             wr_vld,
    input  logic [CNT_W-1:0] wr_pw,
    input  logic             ch_en,
    output logic             pwm,
    output logic             pend
);

    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] active;
    logic             act_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
            active <= '0;
            act_en <= 1'b0;
            pend   <= 1'b0;
            pwm    <= 1'b0;
        end else begin
            // A load coinciding with a write takes the pre-write shadow value.
            if (frame_load) begin
                active <= shadow;
                act_en <= ch_en;
            end
            if (wr_vld) begin
                shadow <= wr_pw;
            end
            if (wr_vld) begin
                pend <= 1'b1;
            end else if (frame_load) begin
                pend <= 1'b0;
            end
            pwm <= act_en && (cnt < active);
        end
    end

endmodule

// File: rtl/servo_pwm_bank.sv
// Multi-channel servo PWM: free-running frame counter, clamped double-buffered widths.
// Latency: outputs registered one clock behind the counter; writes visible from the next frame.
// Backpressure: none, writes are single-cycle strobes; out-of-range channels are dropped.
module servo_pwm_bank
    import servo_pkg::*;
#(
    parameter  int N_CH   = SERVO_N_CH,
    parameter  int CNT_W  = SERVO_CNT_W,
    parameter  int PERIOD = SERVO_PERIOD,
    parameter  int MIN_PW = SERVO_MIN_PW,
    parameter  int MAX_PW = SERVO_MAX_PW,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Wr_En,
    input  logic [CH_W-1:0]  i_Wr_Ch,
    input  logic [CNT_W-1:0] i_Wr_Pw,
    input  logic [N_CH-1:0]  i_Ch_En,
    output logic [N_CH-1:0]  o_Pwm,
    output logic             o_Frame_Start,
    output logic [N_CH-1:0]  o_Pend
);

    logic [CNT_W-1:0] cnt;
    logic             run;
    logic             frame_end;
    logic             frame_load;
    logic [CNT_W-1:0] wr_pw_clamped;

    assign frame_end  = (cnt == CNT_W'(PERIOD - 1));
    assign frame_load = run && frame_end;

    // The first edge after reset release only arms the counter, so cnt=0 gets a full cycle.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            run           <= 1'b0;
            cnt           <= '0;
            o_Frame_Start <= 1'b0;
        end else begin
            run           <= 1'b1;
            o_Frame_Start <= run && (cnt == '0);
            if (run) begin
                cnt <= frame_end ? '0 : cnt + CNT_W'(1);
            end
        end
    end

    // One shared clamp; only the addressed channel captures the result.
    assign wr_pw_clamped = CNT_W'(clamp_pw(32'(i_Wr_Pw), 32'(MIN_PW), 32'(MAX_PW)));

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            logic wr_sel;
            assign wr_sel = i_Wr_En && (i_Wr_Ch == CH_W'(g));

            servo_pwm_channel #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk        (i_Clk),
                .rst_n      (i_Rst_n),
                .cnt        (cnt),
                .frame_load (frame_load),
                .wr_vld     (wr_sel),
                .wr_pw      (wr_pw_clamped),
                .ch_en      (i_Ch_En[g]),
                .pwm        (o_Pwm[g]),
                .pend       (o_Pend[g])
            );
        end
    endgenerate

endmodule

// File: tb/tb_servo_pwm_bank.sv
// Directed bench for servo_pwm_bank with a 100-clock frame and a 10..20 clock pulse window.
module tb_servo_pwm_bank;
    import servo_pkg::*;

    localparam int NC   = 3;
    localparam int CW   = 8;
    localparam int PER  = 100;
    localparam int MINP = 10;
    localparam int MAXP = 20;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          wr_en = 1'b0;
    logic [1:0]    wr_ch = '0;
    logic [CW-1:0] wr_pw = '0;
    logic [NC-1:0] ch_en = 3'b111;
    logic [NC-1:0] pwm;
    logic          fs;
    logic [NC-1:0] pend;

    int total = 0;
    int bad   = 0;
    int pos   = 0;
    int hi[NC];
    int gap[NC];
    int fs_n;
    logic [NC-1:0] pend_98;
    logic [NC-1:0] pend_99;

    always #5 clk = ~clk;

    servo_pwm_bank #(
        .N_CH   (NC),
        .CNT_W  (CW),
        .PERIOD (PER),
        .MIN_PW (MINP),
        .MAX_PW (MAXP)
    ) dut (
        .i_Clk         (clk),
        .i_Rst_n       (rst_n),
        .i_Wr_En       (wr_en),
        .i_Wr_Ch       (wr_ch),
        .i_Wr_Pw       (wr_pw),
        .i_Ch_En       (ch_en),
        .o_Pwm         (pwm),
        .o_Frame_Start (fs),
        .o_Pend        (pend)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // pos tracks the counter value currently reflected on the registered outputs.
    task automatic step();
        @(posedge clk);
        #1;
        pos = (pos + 1) % PER;
    endtask

    // Samples positions pos..99 of the current frame, optionally writing and changing enables.
    task automatic run_frame(input int wr_pos, input logic [1:0] w_ch, input logic [CW-1:0] w_pw,
                             input int en_pos, input logic [NC-1:0] en_val);
        logic [NC-1:0] prev;
        prev = '1;
        for (int c = 0; c < NC; c++) begin
            hi[c]  = 0;
            gap[c] = 0;
        end
        fs_n    = 0;
        pend_98 = '0;
        pend_99 = '0;
        for (int p = pos; p < PER; p++) begin
            for (int c = 0; c < NC; c++) begin
                if (pwm[c]) begin
                    hi[c]++;
                    if (!prev[c]) gap[c] = 1;
                end
            end
            prev = pwm;
            if (fs) fs_n++;
            if (p == 98) pend_98 = pend;
            if (p == 99) pend_99 = pend;
            if (p == wr_pos) begin
                wr_en = 1'b1;
                wr_ch = w_ch;
                wr_pw = w_pw;
            end else begin
                wr_en = 1'b0;
            end
            if (p == en_pos) ch_en = en_val;
            step();
        end
    endtask

    task automatic check_frame(input string f, input int e_pan, input int e_tilt, input int e_fire,
                               input int e_fs, input logic [NC-1:0] e_p98, input logic [NC-1:0] e_p99);
        check({f, "_pan_width"},  hi[CH_PAN],  e_pan);
        check({f, "_tilt_width"}, hi[CH_TILT], e_tilt);
        check({f, "_fire_width"}, hi[CH_FIRE], e_fire);
        check({f, "_shape"}, gap[CH_PAN] + gap[CH_TILT] + gap[CH_FIRE], 0);
        check({f, "_frame_starts"}, fs_n, e_fs);
        check({f, "_pend_at98"}, pend_98, e_p98);
        check({f, "_pend_at99"}, pend_99, e_p99);
    endtask

    initial begin
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_pwm", pwm, 0);
        check("rst_fs", fs, 0);
        check("rst_pend", pend, 0);
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;

        step();
        check("first_edge_fs", fs, 0);
        step();
        pos = 0;
        check("second_edge_fs", fs, 1);
        check("frame0_pwm_at0", pwm, 0);
        check("frame0_pend_at0", pend, 0);

        // Frame 0: program all three channels, including both clamp directions.
        wr_en = 1'b1; wr_ch = 2'd0; wr_pw = 8'd15;
        step();
        check("pend_after_first_wr", pend, 3'b001);
        wr_ch = 2'd1; wr_pw = 8'd5;
        step();
        wr_ch = 2'd2; wr_pw = 8'd200;
        step();
        wr_en = 1'b0;
        check("pend_after_three_wr", pend, 3'b111);
        run_frame(-1, 2'd0, 8'd0, -1, 3'b111);
        check_frame("frame0", 0, 0, 0, 0, 3'b111, 3'b000);
        check("frame1_fs_at0", fs, 1);
        check("frame1_pwm_at0", pwm, 3'b111);

        // Frame 1: clamped widths; a mid-frame write to pan waits for the boundary.
        run_frame(40, 2'd0, 8'd18, -1, 3'b111);
        check_frame("frame1", 15, 10, 20, 1, 3'b001, 3'b000);

        // Frame 2: tilt written on the boundary cycle itself.
        run_frame(98, 2'd1, 8'd12, -1, 3'b111);
        check_frame("frame2", 18, 10, 20, 1, 3'b000, 3'b010);
        check("collide_pend_hold", pend, 3'b010);

        // Frame 3: collision value not yet live; fire enable dropped mid-frame.
        run_frame(-1, 2'd0, 8'd0, 4, 3'b011);
        check_frame("frame3", 18, 10, 20, 1, 3'b010, 3'b000);

        // Frame 4: collision value live, fire silenced, write to a nonexistent channel.
        run_frame(30, 2'd3, 8'd15, -1, 3'b011);
        check_frame("frame4", 18, 12, 0, 1, 3'b000, 3'b000);

        run_frame(-1, 2'd0, 8'd0, -1, 3'b011);
        check_frame("frame5", 18, 12, 0, 1, 3'b000, 3'b000);

        // Asynchronous reset while pan and tilt are high.
        repeat (7) step();
        check("pre_rst_pwm", pwm, 3'b011);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_pwm", pwm, 0);
        check("midrst_fs", fs, 0);
        check("midrst_pend", pend, 0);
        ch_en = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        check("rerun_first_edge_fs", fs, 0);
        step();
        pos = 0;
        check("rerun_second_edge_fs", fs, 1);
        run_frame(-1, 2'd0, 8'd0, -1, 3'b111);
        check_frame("rerun0", 0, 0, 0, 1, 3'b000, 3'b000);
        run_frame(-1, 2'd0, 8'd0, -1, 3'b111);
        check_frame("rerun1", 0, 0, 0, 1, 3'b000, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
